// File: rtl/mem_wb_stage_if.sv
// Handshake and data bundle between the execute stage, the memory/writeback stage
// and the register file. The upstream/downstream environment is the master.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  // Execute-side request
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] write_data;
  logic [REG_W-1:0]  rd;
  logic              is_jump;
  logic              reg_wrenable;
  logic              mem_wrenable;
  logic              mem_to_reg;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic              flush;

  // Writeback-side beat
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_wrenable;
  logic [DATA_W-1:0] wb_data;
  logic              misalign_err;

  modport master (
    output in_valid, alu_res, write_data, rd, is_jump, reg_wrenable, mem_wrenable,
           mem_to_reg, mem_size, mem_unsigned, flush, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_wrenable, wb_data, misalign_err
  );

  modport slave (
    input  in_valid, alu_res, write_data, rd, is_jump, reg_wrenable, mem_wrenable,
           mem_to_reg, mem_size, mem_unsigned, flush, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_wrenable, wb_data, misalign_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: byte-addressed data RAM with sized loads/stores,
// misalignment trapping and a valid/ready writeback output register.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_W  = 5
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);
  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumLanes = DATA_W / 8;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;

  // Request decode
  logic                accept;
  logic                is_mem;
  logic                misaligned;
  logic                do_store;
  logic                do_load;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          offset;
  logic [NumLanes-1:0] lane_en;
  logic [DATA_W-1:0]   lane_data;

  // Writeback register state
  logic                wb_valid_q;
  logic [REG_W-1:0]    wb_rd_q;
  logic                wb_wrenable_q;
  logic                misalign_q;
  logic                is_jump_q;
  logic                is_load_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [1:0]          offset_q;
  logic [DATA_W-1:0]   alu_res_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [DATA_W-1:0]   mem_q [Depth];

  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_val;

  assign bus.in_ready = ~wb_valid_q | bus.wb_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign word_idx     = bus.alu_res[ADDR_W+1:2];
  assign offset       = bus.alu_res[1:0];
  assign is_mem       = bus.mem_wrenable | bus.mem_to_reg;

  always_comb begin
    misaligned = 1'b0;
    unique case (bus.mem_size)
      SzByte:  misaligned = 1'b0;
      SzHalf:  misaligned = offset[0];
      default: misaligned = |offset;
    endcase
    misaligned = misaligned & is_mem;
  end

  // A store landing in the same cycle as reset is dropped.
  assign do_store = accept & bus.mem_wrenable & ~misaligned & rst_n;
  assign do_load  = accept & bus.mem_to_reg & ~bus.mem_wrenable & ~misaligned;

  always_comb begin
    lane_en   = '0;
    lane_data = bus.write_data;
    unique case (bus.mem_size)
      SzByte: begin
        lane_en   = 4'b0001 << offset;
        lane_data = {4{bus.write_data[7:0]}};
      end
      SzHalf: begin
        lane_en   = 4'b0011 << offset;
        lane_data = {2{bus.write_data[15:0]}};
      end
      default: begin
        lane_en   = '1;
        lane_data = bus.write_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (lane_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_wrenable_q <= 1'b0;
      misalign_q    <= 1'b0;
      is_jump_q     <= 1'b0;
      is_load_q     <= 1'b0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      offset_q      <= '0;
      alu_res_q     <= '0;
      write_data_q  <= '0;
      rdata_q       <= '0;
    end else begin
      // Read register only moves on a load accept so a stalled load beat stays put.
      if (do_load) begin
        rdata_q <= mem_q[word_idx];
      end
      if (bus.flush) begin
        wb_valid_q <= 1'b0;
        misalign_q <= 1'b0;
      end else if (accept) begin
        wb_valid_q    <= 1'b1;
        wb_rd_q       <= bus.rd;
        wb_wrenable_q <= bus.reg_wrenable & ~misaligned;
        misalign_q    <= misaligned;
        is_jump_q     <= bus.is_jump;
        is_load_q     <= bus.mem_to_reg & ~bus.mem_wrenable;
        size_q        <= bus.mem_size;
        unsigned_q    <= bus.mem_unsigned;
        offset_q      <= offset;
        alu_res_q     <= bus.alu_res;
        write_data_q  <= bus.write_data;
      end else if (bus.wb_ready) begin
        wb_valid_q <= 1'b0;
        misalign_q <= 1'b0;
      end
    end
  end

  assign shifted = rdata_q >> {offset_q, 3'b000};

  always_comb begin
    load_val = rdata_q;
    unique case (size_q)
      SzByte:  load_val = unsigned_q ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SzHalf:  load_val = unsigned_q ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = rdata_q;
    endcase
  end

  always_comb begin
    bus.wb_data = alu_res_q;
    if (is_jump_q) begin
      bus.wb_data = write_data_q;
    end else if (is_load_q) begin
      bus.wb_data = load_val;
    end
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_wrenable  = wb_wrenable_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage, checked against a byte-array memory model.
module tb_mem_wb_stage;
  localparam int unsigned AddrW = 8;
  localparam int unsigned Bytes = 4 * (2 ** AddrW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_wb_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  mem_wb_stage #(
    .DATA_W(32),
    .ADDR_W(AddrW),
    .REG_W (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ref_mem [Bytes];
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;
  logic [31:0] last_exp;

  logic        p_jump, p_rwe, p_mwe, p_m2r, p_uns;
  logic [1:0]  p_size;
  logic [31:0] p_alu, p_wd;
  logic [4:0]  p_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic jump, input logic rwe, input logic mwe, input logic m2r,
                         input logic [1:0] size, input logic uns, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd);
    p_jump = jump; p_rwe = rwe; p_mwe = mwe; p_m2r = m2r;
    p_size = size; p_uns = uns; p_alu = alu; p_wd = wd; p_rd = rd;
    bus.is_jump      = jump;
    bus.reg_wrenable = rwe;
    bus.mem_wrenable = mwe;
    bus.mem_to_reg   = m2r;
    bus.mem_size     = size;
    bus.mem_unsigned = uns;
    bus.alu_res      = alu;
    bus.write_data   = wd;
    bus.rd           = rd;
    bus.in_valid     = 1'b1;
  endtask

  // Clock the presented op in, apply it to the model, and check the resulting beat.
  task automatic complete(input string tag);
    logic        mis;
    logic [9:0]  a;
    int          nbytes;
    logic [31:0] v;
    logic [31:0] exp_data;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    nbytes = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
    mis = (p_mwe | p_m2r) && ((p_size == 2'd1 && p_alu[0]) || (p_size >= 2'd2 && p_alu[1:0] != 2'd0));
    a = p_alu[9:0];
    if (p_mwe && !mis) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a + 10'(i)] = p_wd[8*i +: 8];
    end
    v = 32'd0;
    for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[a + 10'(i)]) << (8 * i));
    if (!p_uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
    exp_data = p_jump ? p_wd : (p_m2r && !p_mwe) ? v : p_alu;
    last_exp = exp_data;
    check({tag, "/valid"}, 32'(bus.wb_valid), 32'd1);
    check({tag, "/rd"}, 32'(bus.wb_rd), 32'(p_rd));
    check({tag, "/wren"}, 32'(bus.wb_wrenable), 32'(p_rwe && !mis));
    check({tag, "/mis"}, 32'(bus.misalign_err), 32'(mis));
    if (!(mis && p_m2r && !p_mwe && !p_jump)) check({tag, "/data"}, bus.wb_data, exp_data);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    int          kind;

    bus.in_valid = 0; bus.flush = 0; bus.wb_ready = 1;
    bus.is_jump = 0; bus.reg_wrenable = 0; bus.mem_wrenable = 0; bus.mem_to_reg = 0;
    bus.mem_size = 0; bus.mem_unsigned = 0; bus.alu_res = 0; bus.write_data = 0; bus.rd = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst/valid", 32'(bus.wb_valid), 32'd0);
    check("rst/rd", 32'(bus.wb_rd), 32'd0);
    check("rst/wren", 32'(bus.wb_wrenable), 32'd0);
    check("rst/mis", 32'(bus.misalign_err), 32'd0);
    check("rst/in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    for (int w = 0; w < 2 ** AddrW; w++) begin
      present(0, 0, 1, 0, 2'd2, 0, 32'(w * 4), $urandom, 5'd0);
      complete("fill");
    end

    // Word store then load
    present(0, 0, 1, 0, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 5'd0); complete("t1_sw");
    present(0, 1, 0, 1, 2'd2, 0, 32'h10, 32'h0, 5'd3);        complete("t1_lw");
    check("t1_const", bus.wb_data, 32'hDEAD_BEEF);

    // Byte store, signed/unsigned byte loads, word view
    present(0, 0, 1, 0, 2'd0, 0, 32'h21, 32'h0000_0080, 5'd0); complete("t2_sb");
    present(0, 1, 0, 1, 2'd0, 0, 32'h21, 32'h0, 5'd4);         complete("t2_lb");
    check("t2_lb_const", bus.wb_data, 32'hFFFF_FF80);
    present(0, 1, 0, 1, 2'd0, 1, 32'h21, 32'h0, 5'd4);         complete("t2_lbu");
    check("t2_lbu_const", bus.wb_data, 32'h0000_0080);
    present(0, 1, 0, 1, 2'd2, 0, 32'h20, 32'h0, 5'd5);         complete("t2_lw");

    // Misaligned load and store
    present(0, 1, 0, 1, 2'd2, 0, 32'h12, 32'h0, 5'd6);         complete("t3_lw");
    check("t3_mis_const", 32'(bus.misalign_err), 32'd1);
    check("t3_wren_const", 32'(bus.wb_wrenable), 32'd0);
    present(0, 0, 1, 0, 2'd1, 0, 32'h13, 32'h0000_5A5A, 5'd0); complete("t3_sh");
    present(0, 1, 0, 1, 2'd2, 0, 32'h10, 32'h0, 5'd6);         complete("t3_lw_chk");
    check("t3_unchanged", bus.wb_data, 32'hDEAD_BEEF);

    // Output stall holds the beat and blocks new ops
    idle();
    bus.wb_ready = 1'b0;
    present(0, 1, 0, 1, 2'd2, 0, 32'h20, 32'h0, 5'd7);         complete("t4_lw");
    present(0, 0, 1, 0, 2'd2, 0, 32'h30, 32'h1357_9BDF, 5'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
      check("t4_valid", 32'(bus.wb_valid), 32'd1);
      check("t4_data", bus.wb_data, last_exp);
      check("t4_rd", 32'(bus.wb_rd), 32'd7);
    end
    bus.wb_ready = 1'b1;
    #1;
    check("t4_in_ready_rel", 32'(bus.in_ready), 32'd1);
    complete("t4_sw");
    present(0, 1, 0, 1, 2'd2, 0, 32'h30, 32'h0, 5'd8);         complete("t4_lw_chk");

    // Jump writeback
    present(1, 1, 0, 0, 2'd0, 0, 32'h99, 32'h41, 5'd31);       complete("t5_jump");
    check("t5_data_const", bus.wb_data, 32'h41);
    check("t5_rd_const", 32'(bus.wb_rd), 32'd31);

    // Flush drops incoming store and the held beat
    present(0, 0, 1, 0, 2'd2, 0, 32'h40, 32'h1234_5678, 5'd0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_flush_valid", 32'(bus.wb_valid), 32'd0);
    present(0, 1, 0, 1, 2'd2, 0, 32'h40, 32'h0, 5'd9);         complete("t6_lw_chk");
    bus.wb_ready = 1'b0;
    idle();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("t6_flush_held", 32'(bus.wb_valid), 32'd0);

    // Reset during a stall, with a store presented in the same cycle
    present(0, 1, 0, 1, 2'd2, 0, 32'h44, 32'h0, 5'd10);        complete("t6_lw_stall");
    present(0, 0, 1, 0, 2'd2, 0, 32'h44, 32'hCAFE_F00D, 5'd0);
    bus.wb_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("t6_rst_valid", 32'(bus.wb_valid), 32'd0);
    check("t6_rst_mis", 32'(bus.misalign_err), 32'd0);
    present(0, 1, 0, 1, 2'd2, 0, 32'h44, 32'h0, 5'd11);        complete("t6_rst_chk");

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        else if (size >= 2'd2) addr[1:0] = 2'b00;
      end
      present(kind == 3, 1'($urandom), kind == 0, kind == 1, size, 1'($urandom),
              addr, $urandom, 5'($urandom));
      complete("rand");
      if ($urandom_range(0, 7) == 0) idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
